tick_scheduler: RTL and testbench

Multi-channel tick scheduler that shares a single clock prescaler among CHANNELS timing consumers. Each channel has a runtime-programmable period, counted in prescaler strobes, and emits a one-cycle tick pulse and a square-wave toggle output. A valid/ready configuration port loads channel settings. Settings are committed only on a prescaler strobe, so a channel never produces a truncated period. The block replaces per-consumer free-running dividers with one shared, reconfigurable timebase.

---
 rtl/tick_scheduler_if.sv | 30 +++
 rtl/tick_scheduler.sv | 130 +++++++++++++
 tb/tb_tick_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler: one valid/ready write carrying
// a channel index, an enable flag and a period in prescaler strobes.
interface tick_scheduler_if #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CH_W-1:0]        cfg_channel;
    logic                   cfg_enable;
    logic [COUNT_WIDTH-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_channel,
        output cfg_enable,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_channel,
        input  cfg_enable,
        input  cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: CHANNELS programmable periodic tick/wave
// generators whose settings are committed only on a prescaler strobe.
module tick_scheduler #(
    parameter int CHANNELS    = 4,
    parameter int PRESCALE    = 50,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    tick_scheduler_if.slave     cfg,
    output logic                base_tick_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] wave_o
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    logic [PS_W-1:0]        presc_q;
    logic [PS_W-1:0]        presc_d;
    logic                   base_tick_q;

    state_t                 state_q;
    logic                   ready_q;
    logic [CH_W-1:0]        pend_ch_q;
    logic                   pend_en_q;
    logic [COUNT_WIDTH-1:0] pend_period_q;
    logic                   commit;

    assign presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= (presc_q == PS_LAST);
        end
    end

    // A write accepted on a strobe cycle moves to PENDING only after that
    // strobe has been sampled, so it naturally waits for the following one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            pend_ch_q     <= '0;
            pend_en_q     <= 1'b0;
            pend_period_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg.cfg_valid && ready_q) begin
                        pend_ch_q     <= cfg.cfg_channel;
                        pend_en_q     <= cfg.cfg_enable && (cfg.cfg_period != '0);
                        pend_period_q <= cfg.cfg_period;
                        state_q       <= PENDING;
                        ready_q       <= 1'b0;
                    end
                end
                PENDING: begin
                    if (base_tick_q) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign commit        = (state_q == PENDING) && base_tick_q;
    assign cfg.cfg_ready = ready_q;
    assign base_tick_o   = base_tick_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic                   en_q;
        logic [COUNT_WIDTH-1:0] period_q;
        logic [COUNT_WIDTH-1:0] cnt_q;
        logic                   tick_q;
        logic                   wave_q;
        logic                   hit;

        // Out-of-range indices never match any channel and are dropped here.
        assign hit = commit && (pend_ch_q == CH_W'(gi));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                en_q     <= 1'b0;
                period_q <= '0;
                cnt_q    <= '0;
                tick_q   <= 1'b0;
                wave_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (hit) begin
                    if (pend_en_q) begin
                        en_q     <= 1'b1;
                        period_q <= pend_period_q;
                        cnt_q    <= pend_period_q - COUNT_WIDTH'(1);
                    end else begin
                        en_q   <= 1'b0;
                        cnt_q  <= '0;
                        wave_q <= 1'b0;
                    end
                end else if (base_tick_q && en_q) begin
                    if (cnt_q == '0) begin
                        cnt_q  <= period_q - COUNT_WIDTH'(1);
                        tick_q <= 1'b1;
                        wave_q <= ~wave_q;
                    end else begin
                        cnt_q <= cnt_q - COUNT_WIDTH'(1);
                    end
                end
            end
        end

        assign tick_o[gi] = tick_q;
        assign wave_o[gi] = wave_q;
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench: a strobe-arithmetic model predicts every output event,
// a negedge monitor compares whenever the DUT shows base_tick or a tick.
module tb_tick_scheduler;
    localparam int CH = 4;
    localparam int PS = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_scheduler_if #(.CHANNELS(CH), .COUNT_WIDTH(CW)) cfg_a ();
    logic          base_a;
    logic [CH-1:0] tick_a, wave_a;

    tick_scheduler #(.CHANNELS(CH), .PRESCALE(PS), .COUNT_WIDTH(CW)) dut_a (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_a),
        .base_tick_o(base_a), .tick_o(tick_a), .wave_o(wave_a)
    );

    tick_scheduler_if #(.CHANNELS(5), .COUNT_WIDTH(CW)) cfg_b ();
    logic       base_b;
    logic [4:0] tick_b, wave_b;

    tick_scheduler #(.CHANNELS(5), .PRESCALE(PS), .COUNT_WIDTH(CW)) dut_b (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_b),
        .base_tick_o(base_b), .tick_o(tick_b), .wave_o(wave_b)
    );

    typedef struct {
        int            cyc;
        bit            base;
        logic [CH-1:0] tick;
        logic [CH-1:0] wave;
        bit            ready;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: cycle n counts rising edges since reset release.
    // Strobes sit in cycles that are multiples of PS; a channel committed on
    // strobe k with period P ticks in the cycle after strobes k+P, k+2P, ...
    int n;
    bit pend;
    int m_commit, p_ch, p_per, acc_cnt;
    bit p_en;
    bit m_en[CH];
    int m_per[CH];
    int m_k[CH];
    bit m_wave[CH];

    always @(posedge clk or posedge rst) begin
        exp_t e;
        int   cch;
        int   s;
        if (rst) begin
            n = 0;
            pend = 0;
            for (int c = 0; c < CH; c++) begin
                m_en[c] = 0; m_per[c] = 0; m_k[c] = 0; m_wave[c] = 0;
            end
            q.delete();
        end else begin
            n++;
            cch = -1;
            if (pend && n == m_commit + 1) begin
                pend = 0;
                cch  = p_ch;
            end else if (!pend && cfg_a.cfg_valid) begin
                pend     = 1;
                p_ch     = int'(cfg_a.cfg_channel);
                p_per    = int'(cfg_a.cfg_period);
                p_en     = cfg_a.cfg_enable && (p_per != 0);
                m_commit = ((n + PS - 1) / PS) * PS;
                acc_cnt++;
            end
            e.cyc  = n;
            e.base = (n % PS == 0);
            e.tick = '0;
            e.wave = '0;
            for (int c = 0; c < CH; c++) begin
                if (c == cch) begin
                    if (p_en) begin
                        m_en[c] = 1; m_per[c] = p_per; m_k[c] = m_commit / PS;
                    end else begin
                        m_en[c] = 0; m_wave[c] = 0;
                    end
                end else if (m_en[c] && (n % PS == 1)) begin
                    s = (n - 1) / PS;
                    if (s > m_k[c] && ((s - m_k[c]) % m_per[c]) == 0) begin
                        e.tick[c] = 1'b1;
                        m_wave[c] = !m_wave[c];
                    end
                end
                e.wave[c] = m_wave[c];
            end
            e.ready = !pend;
            if (e.base || e.tick != '0) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (q.size() > 0 && q[0].cyc < n) begin
                e = q.pop_front();
                tests++; fails++;
                $display("FAIL missed_event cyc=%0d got no event, required base=%b tick=%b",
                         e.cyc, e.base, e.tick);
            end
            if (base_a || tick_a != '0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_event cyc=%0d got base=%b tick=%b, required none",
                             n, base_a, tick_a);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != n || e.base != base_a || e.tick != tick_a ||
                        e.wave != wave_a || e.ready != cfg_a.cfg_ready) begin
                        fails++;
                        $display("FAIL event cyc=%0d got base=%b tick=%b wave=%b ready=%b, required cyc=%0d base=%b tick=%b wave=%b ready=%b",
                                 n, base_a, tick_a, wave_a, cfg_a.cfg_ready,
                                 e.cyc, e.base, e.tick, e.wave, e.ready);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic do_write(input int ch, input bit en, input int per);
        int c0 = acc_cnt;
        bit ok = 0;
        cfg_a.cfg_channel = 2'(ch);
        cfg_a.cfg_enable  = en;
        cfg_a.cfg_period  = 16'(per);
        cfg_a.cfg_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt != c0) begin ok = 1; break; end
        end
        cfg_a.cfg_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL write_timeout ch=%0d got no acceptance, required acceptance", ch);
        end
    endtask

    task automatic wait_mod(input int r);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((n % PS) == r && !pend) break;
        end
    endtask

    initial begin
        int first, cnt_bad, cnt_base, cnt4, cnt_other;
        cfg_a.cfg_valid = 0; cfg_a.cfg_channel = '0; cfg_a.cfg_enable = 0; cfg_a.cfg_period = '0;
        cfg_b.cfg_valid = 0; cfg_b.cfg_channel = '0; cfg_b.cfg_enable = 0; cfg_b.cfg_period = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_base", int'(base_a), 0);
        check("reset_tick", int'(tick_a), 0);
        check("reset_wave", int'(wave_a), 0);
        check("reset_ready", int'(cfg_a.cfg_ready), 1);
        rst = 1'b0;

        repeat (14) @(negedge clk);
        wait_mod(1);
        do_write(0, 1, 3);
        repeat (30) @(negedge clk);
        wait_mod(0);
        do_write(3, 1, 2);
        repeat (20) @(negedge clk);
        do_write(1, 1, 1);
        do_write(2, 1, 2);
        repeat (20) @(negedge clk);
        do_write(1, 0, 5);
        repeat (20) @(negedge clk);
        do_write(0, 1, 0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            do_write($urandom_range(0, CH - 1), $urandom_range(0, 5) != 0,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 4));
        end
        repeat (40) @(negedge clk);

        do_write(3, 1, 1);
        repeat (12) @(negedge clk);
        do_write(3, 1, 2);
        check("pending_ready", int'(cfg_a.cfg_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("midreset_base", int'(base_a), 0);
        check("midreset_tick", int'(tick_a), 0);
        check("midreset_wave", int'(wave_a), 0);
        check("midreset_ready", int'(cfg_a.cfg_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (base_a) begin first = c; break; end
        end
        check("first_base_after_reset", first, PS);
        repeat (20) @(negedge clk);

        @(negedge clk);
        cfg_b.cfg_channel = 3'd5; cfg_b.cfg_enable = 1; cfg_b.cfg_period = 16'd1;
        cfg_b.cfg_valid = 1;
        @(negedge clk);
        cfg_b.cfg_valid = 0;
        check("b_ready_after_accept", int'(cfg_b.cfg_ready), 0);
        cnt_bad = 0; cnt_base = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tick_b != '0 || wave_b != '0) cnt_bad++;
            if (base_b) cnt_base++;
        end
        check("b_oob_no_activity", cnt_bad, 0);
        check("b_base_count_ok", int'(cnt_base >= 7 && cnt_base <= 8), 1);
        check("b_ready_restored", int'(cfg_b.cfg_ready), 1);
        cfg_b.cfg_channel = 3'd4; cfg_b.cfg_valid = 1;
        @(negedge clk);
        cfg_b.cfg_valid = 0;
        cnt4 = 0; cnt_other = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (tick_b == 5'b10000) cnt4++;
            else if (tick_b != '0) cnt_other++;
        end
        check("b_ch4_ticks_seen", int'(cnt4 >= 4), 1);
        check("b_other_ticks", cnt_other, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
